// File: rtl/timer_pkg.sv
// timer_pkg: shared states, register offsets, MODE encodings and CTRL bit positions for bus_timer.
package timer_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;
  localparam logic [1:0] ADDR_CTRL = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT = 2'd2;
  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD = 2'd1;
  localparam int CTRL_EN = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_IM = 3;
endpackage

// File: rtl/bus_timer.sv
// bus_timer: memory-mapped countdown timer with one-shot / auto-reload modes and a maskable interrupt.
// Optional TIMER_STICKY_IRQ_EN holds irq until the next CTRL or PRESET write.
module bus_timer
  import timer_pkg::*;
#(
  parameter logic [31:0] PRESET_RST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);
  logic [3:0]  r_ctrl;
  logic [31:0] r_preset;
  logic [31:0] r_count;
  state_t      r_state;
  logic        w_wr;
  logic        w_wr_ctrl;
  logic        w_wr_preset;
  logic        w_en;
  logic        w_im;
  logic        w_reload;
  logic        w_unused;
  assign w_wr        = we && (byteen == 4'b1111);
  assign w_wr_ctrl   = w_wr && (addr[3:2] == ADDR_CTRL);
  assign w_wr_preset = w_wr && (addr[3:2] == ADDR_PRESET);
  assign w_en        = r_ctrl[CTRL_EN];
  assign w_im        = r_ctrl[CTRL_IM];
  assign w_reload    = r_ctrl[CTRL_MODE_LSB +: 2] == MODE_RELOAD;
  assign w_unused    = ^{addr[31:4], addr[1:0]};
  assign rdata = (addr[3:2] == ADDR_CTRL)   ? {28'd0, r_ctrl} :
                 (addr[3:2] == ADDR_PRESET) ? r_preset :
                 (addr[3:2] == ADDR_COUNT)  ? r_count : 32'd0;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ctrl   <= 4'd0;
      r_preset <= PRESET_RST;
      r_count  <= 32'd0;
      r_state  <= IDLE;
    end else begin
      if (w_wr_preset) r_preset <= wdata;
      case (r_state)
        IDLE: if (w_en) r_state <= LOAD;
        LOAD: begin
          if (!w_en) r_state <= IDLE;
          else begin
            r_count <= r_preset;
            r_state <= CNT;
          end
        end
        CNT: begin
          if (!w_en) r_state <= IDLE;
          else if (r_count > 32'd1) r_count <= r_count - 32'd1;
          else begin
            r_count <= 32'd0;
            r_state <= INT;
          end
        end
        INT: begin
          if (!w_reload) begin
            r_ctrl[CTRL_EN] <= 1'b0;
            r_state         <= IDLE;
          end else r_state <= w_en ? LOAD : IDLE;
        end
      endcase
      // placed after the FSM so a bus write overrides the one-shot EN clear
      if (w_wr_ctrl) r_ctrl <= wdata[3:0];
    end
  end
`ifdef TIMER_STICKY_IRQ_EN
  logic r_flag;
  logic w_int_entry;
  assign w_int_entry = (r_state == CNT) && w_en && (r_count <= 32'd1);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_flag <= 1'b0;
    else if (w_int_entry) r_flag <= 1'b1;
    else if (w_wr_ctrl || w_wr_preset) r_flag <= 1'b0;
  end
  assign irq = r_flag & w_im;
`else
  assign irq = w_im & (r_state == INT);
`endif
endmodule

// File: tb/tb_bus_timer.sv
// tb_bus_timer: directed scoreboard bench for bus_timer (default and TIMER_STICKY_IRQ_EN builds).
module tb_bus_timer;
  import timer_pkg::*;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] addr = 32'd0;
  logic        we = 1'b0;
  logic [3:0]  byteen = 4'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        irq;
  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
`ifdef TIMER_STICKY_IRQ_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif
  bus_timer dut (
    .clk(clk), .reset(reset), .addr(addr), .we(we),
    .byteen(byteen), .wdata(wdata), .rdata(rdata), .irq(irq)
  );
  always #5 clk = ~clk;
  task automatic push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    n_chk++;
    if (exp_q.size() == 0) begin
      n_err++;
      $error("FAIL %s: observed %h, scoreboard empty", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_err++;
        $error("FAIL %s: observed %h expected %h", tag, obs, e);
      end
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be = 4'hF);
    addr = {28'd0, a, 2'b00};
    wdata = d;
    byteen = be;
    we = 1'b1;
    @(negedge clk);
    we = 1'b0;
    byteen = 4'd0;
  endtask
  task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] e);
    push(e);
    addr = {28'd0, a, 2'b00};
    #1;
    chk(tag, rdata);
  endtask
  task automatic irq_chk(input string tag, input logic e);
    push({31'd0, e});
    chk(tag, {31'd0, irq});
  endtask
  initial begin
    cyc(2);
    rd("rst_ctrl", ADDR_CTRL, 32'd0);
    rd("rst_preset", ADDR_PRESET, 32'd0);
    rd("rst_count", ADDR_COUNT, 32'd0);
    irq_chk("rst_irq", 1'b0);
    cyc(1);
    reset = 1'b1;
    cyc(1);
    // reset asserted mid-count
    wr(ADDR_PRESET, 32'd10);
    wr(ADDR_CTRL, 32'h9);
    cyc(4);
    rd("mid_count", ADDR_COUNT, 32'd8);
    #2 reset = 1'b0;
    #1;
    rd("arst_ctrl", ADDR_CTRL, 32'd0);
    rd("arst_preset", ADDR_PRESET, 32'd0);
    rd("arst_count", ADDR_COUNT, 32'd0);
    irq_chk("arst_irq", 1'b0);
    cyc(1);
    reset = 1'b1;
    cyc(5);
    rd("arst_hold_count", ADDR_COUNT, 32'd0);
    irq_chk("arst_hold_irq", 1'b0);
    // one-shot, PRESET 5
    wr(ADDR_PRESET, 32'd5);
    wr(ADDR_CTRL, 32'h9);
    cyc(2);
    rd("os_count_e2", ADDR_COUNT, 32'd5);
    cyc(4);
    rd("os_count_e6", ADDR_COUNT, 32'd1);
    irq_chk("os_irq_e6", 1'b0);
    cyc(1);
    irq_chk("os_irq_e7", 1'b1);
    rd("os_count_e7", ADDR_COUNT, 32'd0);
    cyc(1);
    rd("os_ctrl_e8", ADDR_CTRL, 32'h8);
    irq_chk("os_irq_e8", STICKY);
    cyc(3);
    irq_chk("os_irq_e11", STICKY);
    rd("os_count_e11", ADDR_COUNT, 32'd0);
    wr(ADDR_CTRL, 32'h0);
    irq_chk("os_irq_clr", 1'b0);
    // auto-reload, PRESET 3, period 5
    wr(ADDR_PRESET, 32'd3);
    for (int i = 1; i <= 16; i++)
      push({31'd0, STICKY ? (i >= 5) : (i == 5 || i == 10 || i == 15)});
    wr(ADDR_CTRL, 32'hB);
    for (int i = 1; i <= 16; i++) begin
      cyc(1);
      chk($sformatf("ar_irq_e%0d", i), {31'd0, irq});
    end
    wr(ADDR_CTRL, 32'h0);
    cyc(2);
    irq_chk("ar_stop_irq", 1'b0);
    // masked: reaches INT, irq stays low
    wr(ADDR_PRESET, 32'd2);
    wr(ADDR_CTRL, 32'h1);
    for (int i = 1; i <= 6; i++) begin
      cyc(1);
      irq_chk($sformatf("mask_irq_e%0d", i), 1'b0);
      if (i == 4) rd("mask_ctrl_e4", ADDR_CTRL, 32'h1);
      if (i == 5) rd("mask_ctrl_e5", ADDR_CTRL, 32'h0);
    end
    // bus rules
    wr(ADDR_COUNT, 32'hFFFF);
    rd("ro_count", ADDR_COUNT, 32'd0);
    wr(ADDR_PRESET, 32'hAAAA, 4'b0011);
    rd("partial_preset", ADDR_PRESET, 32'd2);
    wr(2'd3, 32'hFFFF_FFFF);
    rd("reserved", 2'd3, 32'd0);
    // PRESET rewrite mid-count lands at next reload
    wr(ADDR_PRESET, 32'd6);
    wr(ADDR_CTRL, 32'hB);
    cyc(3);
    wr(ADDR_PRESET, 32'd7);
    rd("pw_count_e4", ADDR_COUNT, 32'd4);
    cyc(3);
    irq_chk("pw_irq_e7", 1'b0);
    cyc(1);
    irq_chk("pw_irq_e8", 1'b1);
    cyc(2);
    rd("pw_reload", ADDR_COUNT, 32'd7);
    wr(ADDR_CTRL, 32'h0);
    cyc(2);
    // collision: CTRL write in INT state of one-shot
    wr(ADDR_PRESET, 32'd2);
    wr(ADDR_CTRL, 32'h9);
    cyc(4);
    irq_chk("col_irq_e4", 1'b1);
    wr(ADDR_CTRL, 32'h9);
    rd("col_ctrl_e5", ADDR_CTRL, 32'h9);
    irq_chk("col_irq_e5", 1'b0);
    cyc(2);
    rd("col_count_e7", ADDR_COUNT, 32'd2);
    cyc(2);
    irq_chk("col_irq_e9", 1'b1);
    wr(ADDR_CTRL, 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
